// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage controller.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_REQ,
    ST_HOLD,
    ST_DRAIN
  } fetch_state_e;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_hold_reg.sv
// Holds one fetched instruction and its pc while decode is stalled.
module fetch_hold_reg
  import fetch_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            clear,
  input  logic [XLEN-1:0] instr_in,
  input  logic [XLEN-1:0] pc_in,
  output logic [XLEN-1:0] instr_out,
  output logic [XLEN-1:0] pc_out,
  output logic            valid_out
);

  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            valid_q, valid_d;

  // Clear wins over load so a redirect always empties the register.
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (clear) begin
      instr_d = NOP_INSTR;
      pc_d    = '0;
      valid_d = 1'b0;
    end else if (load) begin
      instr_d = instr_in;
      pc_d    = pc_in;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign instr_out = instr_q;
  assign pc_out    = pc_q;
  assign valid_out = valid_q;

endmodule

// File: rtl/fetch_stage_ctrl.sv
// Fetch stage controller: pc sequencing, decode-stall holding and branch redirect/drain.
// Optional perf counters (stall_cycles, flush_count) under FETCH_STAGE_CTRL_PERF_EN.
module fetch_stage_ctrl
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            imem_ready,
  input  logic            stall_id,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic            if_valid,
  output logic [XLEN-1:0] if_instruction,
  output logic [XLEN-1:0] if_pc,
  output logic            ifid_en,
  output logic            ifid_flush
`ifdef FETCH_STAGE_CTRL_PERF_EN
  ,
  output logic [31:0]     stall_cycles,
  output logic [31:0]     flush_count
`endif
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] drain_addr_q, drain_addr_d;

  logic            hold_load;
  logic            hold_clear;
  logic [XLEN-1:0] hold_instr;
  logic [XLEN-1:0] hold_pc;
  logic            hold_valid;

  fetch_hold_reg u_hold (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (hold_load),
    .clear     (hold_clear),
    .instr_in  (imem_rdata),
    .pc_in     (pc_q),
    .instr_out (hold_instr),
    .pc_out    (hold_pc),
    .valid_out (hold_valid)
  );

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    drain_addr_d   = drain_addr_q;
    hold_load      = 1'b0;
    hold_clear     = 1'b0;
    imem_req       = 1'b0;
    imem_addr      = pc_q;
    if_valid       = 1'b0;
    if_instruction = NOP_INSTR;
    if_pc          = pc_q;
    ifid_en        = 1'b0;
    ifid_flush     = 1'b0;

    case (state_q)
      ST_BOOT: state_d = ST_REQ;
      ST_REQ: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          if_valid       = 1'b1;
          if_instruction = imem_rdata;
          if (stall_id) begin
            hold_load = 1'b1;
            state_d   = ST_HOLD;
          end else begin
            ifid_en = 1'b1;
            pc_d    = pc_q + 32'd4;
          end
        end
      end
      ST_HOLD: begin
        if_valid       = hold_valid;
        if_instruction = hold_instr;
        if_pc          = hold_pc;
        ifid_en        = ~stall_id;
        if (!stall_id) begin
          pc_d       = pc_q + 32'd4;
          hold_clear = 1'b1;
          state_d    = ST_REQ;
        end
      end
      ST_DRAIN: begin
        // The stale request must complete at its original address before redirecting.
        imem_req  = 1'b1;
        imem_addr = drain_addr_q;
        if (imem_ready) state_d = ST_REQ;
      end
      default: state_d = ST_BOOT;
    endcase

    if (branch_taken) begin
      ifid_flush     = 1'b1;
      if_valid       = 1'b0;
      if_instruction = NOP_INSTR;
      ifid_en        = 1'b0;
      hold_load      = 1'b0;
      hold_clear     = 1'b1;
      pc_d           = word_align(branch_target);
      if ((state_q == ST_REQ) && !imem_ready) begin
        drain_addr_d = pc_q;
        state_d      = ST_DRAIN;
      end else if ((state_q == ST_DRAIN) && !imem_ready) begin
        state_d = ST_DRAIN;
      end else begin
        state_d = ST_REQ;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_BOOT;
      pc_q         <= RESET_PC;
      drain_addr_q <= RESET_PC;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
    end
  end

`ifdef FETCH_STAGE_CTRL_PERF_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_count_q, flush_count_d;

  // Both counters saturate at all-ones instead of wrapping.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if ((state_q == ST_HOLD) && (stall_cycles_q != 32'hFFFF_FFFF))
      stall_cycles_d = stall_cycles_q + 32'd1;
    if (branch_taken && (flush_count_q != 32'hFFFF_FFFF))
      flush_count_d = flush_count_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// Directed self-checking bench for fetch_stage_ctrl: sequential fetch, stall/hold,
// branch flush, drain with last-target-wins, pc wraparound and async reset during drain.
module tb_fetch_stage_ctrl;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        stall_id;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        if_valid;
  logic [31:0] if_instruction;
  logic [31:0] if_pc;
  logic        ifid_en;
  logic        ifid_flush;

  int checkCount = 0;
  int failCount  = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  always #5 clk = ~clk;

  fetch_stage_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .imem_ready     (imem_ready),
    .stall_id       (stall_id),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .if_valid       (if_valid),
    .if_instruction (if_instruction),
    .if_pc          (if_pc),
    .ifid_en        (ifid_en),
    .ifid_flush     (ifid_flush)
  );

  // Every comparison funnels through here so the counters stay honest.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns later, well clear of the rising edge.
  task automatic applyStimulus(input logic rstnIn, input logic readyIn, input logic stallIn,
                               input logic branchIn, input logic [31:0] targetIn,
                               input logic [31:0] rdataIn);
    @(negedge clk);
    rst_n         = rstnIn;
    imem_ready    = readyIn;
    stall_id      = stallIn;
    branch_taken  = branchIn;
    branch_target = targetIn;
    imem_rdata    = rdataIn;
    #1;
  endtask

  // Address is only meaningful with a request, pc only with a valid instruction.
  task automatic expectFetch(input string tag, input logic req, input logic [31:0] addr,
                             input logic valid, input logic [31:0] instr, input logic [31:0] pc,
                             input logic en, input logic flush);
    checkOutput({tag, ".req"}, {31'b0, imem_req}, {31'b0, req});
    if (req) checkOutput({tag, ".addr"}, imem_addr, addr);
    checkOutput({tag, ".valid"}, {31'b0, if_valid}, {31'b0, valid});
    checkOutput({tag, ".instr"}, if_instruction, instr);
    if (valid) checkOutput({tag, ".pc"}, if_pc, pc);
    checkOutput({tag, ".en"}, {31'b0, ifid_en}, {31'b0, en});
    checkOutput({tag, ".flush"}, {31'b0, ifid_flush}, {31'b0, flush});
  endtask

  initial begin
    rst_n         = 1'b0;
    imem_ready    = 1'b0;
    stall_id      = 1'b0;
    branch_taken  = 1'b0;
    branch_target = '0;
    imem_rdata    = '0;
    #2;
    expectFetch("reset", 1'b0, 32'h0, 1'b0, NOP, 32'h0, 1'b0, 1'b0);
    checkOutput("reset.if_pc", if_pc, 32'h0);

    $display("[TB] sequential fetch");
    applyStimulus(1, 1, 0, 0, 32'h0, 32'h1111_0000);
    expectFetch("boot", 1'b0, 32'h0, 1'b0, NOP, 32'h0, 1'b0, 1'b0);
    applyStimulus(1, 1, 0, 0, 32'h0, 32'h1111_0000);
    expectFetch("f0", 1'b1, 32'h0, 1'b1, 32'h1111_0000, 32'h0, 1'b1, 1'b0);
    applyStimulus(1, 1, 0, 0, 32'h0, 32'h1111_0004);
    expectFetch("f4", 1'b1, 32'h4, 1'b1, 32'h1111_0004, 32'h4, 1'b1, 1'b0);

    $display("[TB] decode stall at 0x8");
    applyStimulus(1, 1, 1, 0, 32'h0, 32'h1111_0008);
    checkOutput("cap.req", {31'b0, imem_req}, 32'h1);
    checkOutput("cap.addr", imem_addr, 32'h8);
    checkOutput("cap.en", {31'b0, ifid_en}, 32'h0);
    checkOutput("cap.flush", {31'b0, ifid_flush}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 1, 0, 32'h0, 32'hDEAD_BEEF);
      expectFetch("hold", 1'b0, 32'h0, 1'b1, 32'h1111_0008, 32'h8, 1'b0, 1'b0);
    end
    applyStimulus(1, 0, 0, 0, 32'h0, 32'hDEAD_BEEF);
    expectFetch("unhold", 1'b0, 32'h0, 1'b1, 32'h1111_0008, 32'h8, 1'b1, 1'b0);
    applyStimulus(1, 1, 0, 0, 32'h0, 32'h1111_000C);
    expectFetch("fC", 1'b1, 32'hC, 1'b1, 32'h1111_000C, 32'hC, 1'b1, 1'b0);

    $display("[TB] branch with data returning");
    applyStimulus(1, 1, 0, 1, 32'h0000_0103, 32'h1111_0010);
    expectFetch("br103", 1'b1, 32'h10, 1'b0, NOP, 32'h0, 1'b0, 1'b1);
    applyStimulus(1, 1, 0, 0, 32'h0, 32'h2222_0100);
    expectFetch("f100", 1'b1, 32'h100, 1'b1, 32'h2222_0100, 32'h100, 1'b1, 1'b0);

    $display("[TB] branch with request outstanding");
    applyStimulus(1, 1, 0, 1, 32'h0000_0040, 32'h2222_0104);
    expectFetch("br40", 1'b1, 32'h104, 1'b0, NOP, 32'h0, 1'b0, 1'b1);
    applyStimulus(1, 0, 0, 0, 32'h0, 32'h0);
    expectFetch("wait40", 1'b1, 32'h40, 1'b0, NOP, 32'h0, 1'b0, 1'b0);
    applyStimulus(1, 0, 0, 1, 32'h0000_0200, 32'h0);
    expectFetch("br200", 1'b1, 32'h40, 1'b0, NOP, 32'h0, 1'b0, 1'b1);
    applyStimulus(1, 0, 0, 0, 32'h0, 32'h0);
    expectFetch("drain0", 1'b1, 32'h40, 1'b0, NOP, 32'h0, 1'b0, 1'b0);
    applyStimulus(1, 1, 0, 0, 32'h0, 32'h3333_0040);
    expectFetch("drain1", 1'b1, 32'h40, 1'b0, NOP, 32'h0, 1'b0, 1'b0);
    applyStimulus(1, 1, 0, 0, 32'h0, 32'h4444_0200);
    expectFetch("f200", 1'b1, 32'h200, 1'b1, 32'h4444_0200, 32'h200, 1'b1, 1'b0);

    $display("[TB] second branch during drain");
    applyStimulus(1, 0, 0, 1, 32'h0000_0500, 32'h0);
    expectFetch("br500", 1'b1, 32'h204, 1'b0, NOP, 32'h0, 1'b0, 1'b1);
    applyStimulus(1, 0, 0, 1, 32'h0000_0602, 32'h0);
    expectFetch("br600", 1'b1, 32'h204, 1'b0, NOP, 32'h0, 1'b0, 1'b1);
    applyStimulus(1, 1, 0, 0, 32'h0, 32'h5555_0204);
    expectFetch("drain2", 1'b1, 32'h204, 1'b0, NOP, 32'h0, 1'b0, 1'b0);
    applyStimulus(1, 1, 0, 0, 32'h0, 32'h6666_0600);
    expectFetch("f600", 1'b1, 32'h600, 1'b1, 32'h6666_0600, 32'h600, 1'b1, 1'b0);

    $display("[TB] pc wraparound");
    applyStimulus(1, 1, 0, 1, 32'hFFFF_FFFE, 32'h0);
    expectFetch("brTop", 1'b1, 32'h604, 1'b0, NOP, 32'h0, 1'b0, 1'b1);
    applyStimulus(1, 1, 0, 0, 32'h0, 32'h7777_FFFC);
    expectFetch("fTop", 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h7777_FFFC, 32'hFFFF_FFFC, 1'b1, 1'b0);

    $display("[TB] async reset during drain");
    applyStimulus(1, 0, 0, 1, 32'h0000_0800, 32'h0);
    expectFetch("wrap", 1'b1, 32'h0, 1'b0, NOP, 32'h0, 1'b0, 1'b1);
    applyStimulus(1, 0, 0, 0, 32'h0, 32'h0);
    expectFetch("drain3", 1'b1, 32'h0, 1'b0, NOP, 32'h0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    expectFetch("rstAsync", 1'b0, 32'h0, 1'b0, NOP, 32'h0, 1'b0, 1'b0);
    checkOutput("rstAsync.if_pc", if_pc, 32'h0);
    applyStimulus(0, 1, 0, 0, 32'h0, 32'h0);
    expectFetch("rstHeld", 1'b0, 32'h0, 1'b0, NOP, 32'h0, 1'b0, 1'b0);
    applyStimulus(1, 1, 0, 0, 32'h0, 32'h1111_0000);
    expectFetch("boot2", 1'b0, 32'h0, 1'b0, NOP, 32'h0, 1'b0, 1'b0);
    applyStimulus(1, 1, 0, 0, 32'h0, 32'h1111_0000);
    expectFetch("restart", 1'b1, 32'h0, 1'b1, 32'h1111_0000, 32'h0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
